// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter for the shared FIFO write port; stalls producers on w_full.
// Optional burst locking is compiled in with `define FIFO_ARB_BURST_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_SIZE = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                         w_clk,
  input  logic                         w_rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data,
  output logic [NUM_REQ-1:0]           gnt,
  input  logic                         w_full,
  output logic                         w_en,
  output logic [DATA_SIZE-1:0]         w_data,
  output logic [$clog2(NUM_REQ)-1:0]   owner,
  output logic                         busy
);

  localparam int unsigned OW = $clog2(NUM_REQ);
`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned BW = $clog2(MAX_BURST + 1);
`endif

  typedef enum logic {IDLE, OWN} state_t;

  state_t              r_state, w_state_nxt;
  logic [OW-1:0]       r_owner, w_owner_nxt;
  logic [OW-1:0]       r_last,  w_last_nxt;
  logic                w_xfer;
  logic                w_release;
  logic                w_others;
  logic [NUM_REQ-1:0]  w_owner_mask;
`ifdef FIFO_ARB_BURST_EN
  logic [BW-1:0]       r_beat_cnt, w_beat_nxt;
`endif

  // First requester after lst, wrapping; lst itself is scanned last.
  function automatic logic [OW-1:0] pick(input logic [NUM_REQ-1:0] rq,
                                         input logic [OW-1:0]      lst);
    logic [OW-1:0] res;
    logic [OW-1:0] idx;
    res = lst;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(lst) + k) % NUM_REQ);
      if (rq[idx]) res = idx;
    end
    return res;
  endfunction

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= IDLE;
      r_owner    <= '0;
      r_last     <= OW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      r_beat_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_last     <= w_last_nxt;
`ifdef FIFO_ARB_BURST_EN
      r_beat_cnt <= w_beat_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_last_nxt   = r_last;
    gnt          = '0;
    w_en         = 1'b0;
    w_data       = '0;
    w_xfer       = 1'b0;
    w_release    = 1'b0;
    w_owner_mask = '0;
    w_others     = 1'b0;
`ifdef FIFO_ARB_BURST_EN
    w_beat_nxt   = r_beat_cnt;
`endif

    case (r_state)
      IDLE: begin
        if (|req) begin
          w_owner_nxt = pick(req, r_last);
          w_state_nxt = OWN;
`ifdef FIFO_ARB_BURST_EN
          w_beat_nxt  = '0;
`endif
        end
      end

      OWN: begin
        gnt[r_owner] = req[r_owner] & ~w_full;
        w_xfer       = req[r_owner] & ~w_full;
        w_en         = w_xfer;
        w_data       = req_data[int'(r_owner)*DATA_SIZE +: DATA_SIZE];

`ifdef FIFO_ARB_BURST_EN
        if (w_xfer) w_beat_nxt = r_beat_cnt + 1'b1;
        w_release = ~req[r_owner] | (w_xfer & (r_beat_cnt == BW'(MAX_BURST - 1)));
`else
        w_release = ~req[r_owner] | w_xfer;
`endif

        // Hand off without a bubble when anyone else is waiting.
        w_owner_mask[r_owner] = 1'b1;
        w_others              = |(req & ~w_owner_mask);
        if (w_release) begin
          w_last_nxt = r_owner;
`ifdef FIFO_ARB_BURST_EN
          w_beat_nxt = '0;
`endif
          if (w_others) w_owner_nxt = pick(req, r_owner);
          else          w_state_nxt = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign owner = r_owner;
  assign busy  = (r_state == OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios via an expected-value
// queue, plus a multi-producer run into a modelled FIFO with per-producer scoreboards.
module tb_fifo_wr_arbiter;

  localparam int unsigned NR    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned BEATS = 8;

  localparam logic [7:0] L0 = 8'hA0;
  localparam logic [7:0] L1 = 8'hB1;
  localparam logic [7:0] L2 = 8'hC2;
  localparam logic [7:0] L3 = 8'hD3;

  typedef struct packed {
    logic [3:0] gnt;
    logic       en;
    logic [7:0] data;
    logic [1:0] own;
    logic       bsy;
  } exp_t;

  logic           w_clk;
  logic           w_rst_n;
  logic [NR-1:0]  req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]  gnt;
  logic           w_full;
  logic           w_en;
  logic [DW-1:0]  w_data;
  logic [1:0]     owner;
  logic           busy;

  int   n_tests;
  int   n_fail;
  exp_t exp_q[$];
  logic [7:0] sb_q[0:3][$];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_BURST(4)) dut (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .w_full   (w_full),
    .w_en     (w_en),
    .w_data   (w_data),
    .owner    (owner),
    .busy     (busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(input exp_t v);
    return $sformatf("gnt=%b w_en=%b w_data=%h owner=%0d busy=%b", v.gnt, v.en, v.data, v.own, v.bsy);
  endfunction

  function automatic exp_t mk(input logic [3:0] g, input logic e, input logic [7:0] d,
                              input logic [1:0] o, input logic b);
    exp_t v;
    v.gnt = g; v.en = e; v.data = d; v.own = o; v.bsy = b;
    return v;
  endfunction

  // Leaves the DUT idle just after a rising edge with reset released.
  task automatic reset_dut();
    w_rst_n  = 1'b0;
    req      = '0;
    w_full   = 1'b0;
    req_data = {L3, L2, L1, L0};
    exp_q.delete();
    @(posedge w_clk);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    @(posedge w_clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t o, e;
    reset_dut();
    req = 4'b1111;
    exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b0001, 1'b1, L0, 2'd0, 1'b1));
    for (int c = 0; c < 2; c++) begin
      @(negedge w_clk);
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_pre c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
    // Assert reset asynchronously while a grant is active.
    #2 w_rst_n = 1'b0;
    #1;
    o = exp_t'({gnt, w_en, w_data, owner, busy});
    e = mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_async: got %s, expected %s", fmt(o), fmt(e));
    end
    @(negedge w_clk);
    w_rst_n = 1'b1;
    exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
    exp_q.push_back(mk(4'b0001, 1'b1, L0, 2'd0, 1'b1));
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge w_clk);
      else #1;
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_post c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
  endtask

`ifndef FIFO_ARB_BURST_EN
  task automatic test_round_robin();
    exp_t o, e;
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      req = 4'b0101;
      if (c == 0)          exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
      else if (c % 2 == 1) exp_q.push_back(mk(4'b0001, 1'b1, L0, 2'd0, 1'b1));
      else                 exp_q.push_back(mk(4'b0100, 1'b1, L2, 2'd2, 1'b1));
      @(negedge w_clk);
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL round_robin c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
  endtask

  task automatic test_full_stall();
    exp_t o, e;
    reset_dut();
    for (int c = 0; c < 8; c++) begin
      req    = 4'b0110;
      w_full = (c >= 3 && c <= 5);
      case (c)
        0:       exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
        1, 6:    exp_q.push_back(mk(4'b0010, 1'b1, L1, 2'd1, 1'b1));
        2, 7:    exp_q.push_back(mk(4'b0100, 1'b1, L2, 2'd2, 1'b1));
        default: exp_q.push_back(mk(4'b0000, 1'b0, L1, 2'd1, 1'b1));
      endcase
      @(negedge w_clk);
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL full_stall c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
    w_full = 1'b0;
  endtask
`else
  task automatic test_burst();
    exp_t o, e;
    reset_dut();
    for (int c = 0; c < 13; c++) begin
      req = 4'b0011;
      if (c == 0)                exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
      else if (c >= 5 && c <= 8) exp_q.push_back(mk(4'b0010, 1'b1, L1, 2'd1, 1'b1));
      else                       exp_q.push_back(mk(4'b0001, 1'b1, L0, 2'd0, 1'b1));
      @(negedge w_clk);
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL burst c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
  endtask

  task automatic test_full_stall();
    exp_t o, e;
    reset_dut();
    for (int c = 0; c < 13; c++) begin
      req    = 4'b0011;
      w_full = (c >= 7 && c <= 9);
      if (c == 0)                  exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
      else if (c <= 4 || c == 12)  exp_q.push_back(mk(4'b0001, 1'b1, L0, 2'd0, 1'b1));
      else if (c >= 7 && c <= 9)   exp_q.push_back(mk(4'b0000, 1'b0, L1, 2'd1, 1'b1));
      else                         exp_q.push_back(mk(4'b0010, 1'b1, L1, 2'd1, 1'b1));
      @(negedge w_clk);
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL full_stall c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
    w_full = 1'b0;
  endtask
`endif

  task automatic test_drop_handoff();
    exp_t o, e;
    reset_dut();
    for (int c = 0; c < 5; c++) begin
      case (c)
        0: begin
          req = 4'b1100; w_full = 1'b1;
          exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd0, 1'b0));
        end
        1: begin
          req = 4'b1000; w_full = 1'b0;
          exp_q.push_back(mk(4'b0000, 1'b0, L2, 2'd2, 1'b1));
        end
        2: begin
          req = 4'b1000;
          exp_q.push_back(mk(4'b1000, 1'b1, L3, 2'd3, 1'b1));
        end
        3: begin
          req = 4'b0000;
`ifdef FIFO_ARB_BURST_EN
          exp_q.push_back(mk(4'b0000, 1'b0, L3, 2'd3, 1'b1));
`else
          exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd3, 1'b0));
`endif
        end
        default: begin
          req = 4'b0000;
          exp_q.push_back(mk(4'b0000, 1'b0, 8'h00, 2'd3, 1'b0));
        end
      endcase
      @(negedge w_clk);
      o = exp_t'({gnt, w_en, w_data, owner, busy});
      e = exp_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL drop_handoff c%0d: got %s, expected %s", c, fmt(o), fmt(e));
      end
      @(posedge w_clk);
      #1;
    end
  endtask

  // Four producers with tagged beats feeding a modelled FIFO drained at random.
  task automatic test_system();
    int          sent[NR];
    int          total;
    int          cycles;
    int          fifo_cnt;
    logic        rd;
    logic [NR-1:0] acc;
    logic [1:0]  p;
    logic [7:0]  tag;
    reset_dut();
    for (int i = 0; i < NR; i++) begin
      sent[i] = 0;
      sb_q[i].delete();
    end
    total    = 0;
    cycles   = 0;
    fifo_cnt = 0;
    while (total < NR * BEATS && cycles < 3000) begin
      for (int i = 0; i < NR; i++) begin
        if (!req[i] && sent[i] < BEATS && $urandom_range(3) != 0) begin
          tag = {2'(i), 6'(sent[i])};
          req[i] = 1'b1;
          req_data[i*DW +: DW] = tag;
          sb_q[i].push_back(tag);
        end
      end
      w_full = (fifo_cnt == DEPTH);
      rd     = ($urandom_range(2) == 0);
      @(negedge w_clk);
      n_tests++;
      if ($countones(gnt) > 1) begin
        n_fail++;
        $display("FAIL sys_onehot cycle %0d: got gnt=%b, expected at most one bit", cycles, gnt);
      end
      n_tests++;
      if (w_en && w_full) begin
        n_fail++;
        $display("FAIL sys_full_write cycle %0d: got w_en=1 with w_full=1, expected w_en=0", cycles);
      end
      acc = req & gnt;
      if (w_en) begin
        p = w_data[7:6];
        n_tests++;
        if (sb_q[p].size() == 0 || gnt[p] !== 1'b1 || w_data !== sb_q[p][0]) begin
          n_fail++;
          $display("FAIL sys_data cycle %0d: got w_data=%h gnt=%b, expected %h from producer %0d",
                   cycles, w_data, gnt, (sb_q[p].size() != 0) ? sb_q[p][0] : 8'hxx, p);
        end
        if (sb_q[p].size() != 0) void'(sb_q[p].pop_front());
      end
      @(posedge w_clk);
      #1;
      fifo_cnt = fifo_cnt + (w_en ? 1 : 0) - ((rd && fifo_cnt > 0) ? 1 : 0);
      for (int i = 0; i < NR; i++) begin
        if (acc[i]) begin
          req[i]  = 1'b0;
          sent[i] = sent[i] + 1;
          total   = total + 1;
        end
      end
      cycles++;
    end
    req = '0;
    n_tests++;
    if (total != NR * BEATS) begin
      n_fail++;
      $display("FAIL sys_count: got %0d beats accepted, expected %0d", total, NR * BEATS);
    end
    for (int i = 0; i < NR; i++) begin
      n_tests++;
      if (sb_q[i].size() != 0) begin
        n_fail++;
        $display("FAIL sys_leftover producer %0d: got %0d beats unwritten, expected 0", i, sb_q[i].size());
      end
    end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    w_rst_n  = 1'b0;
    req      = '0;
    req_data = '0;
    w_full   = 1'b0;
    test_reset();
`ifndef FIFO_ARB_BURST_EN
    test_round_robin();
`else
    test_burst();
`endif
    test_full_stall();
    test_drop_handoff();
    test_system();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
